fetch_ctrl: RTL and testbench

Fetch sequencer driving the IR's write/read protocol. Holds the program counter, runs a request/acknowledge transaction to instruction memory, and loads each returned word into the IR with `IR_wr`. It then reads the word out with `IR_rd` and presents it to decode with a valid/stall handshake. It also handles branch redirects from execute, including squashing an in-flight fetch.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_pc.sv | 61 ++++++
 rtl/fetch_ctrl.sv | 98 +++++++++
 tb/tb_fetch_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding and default PC constants,
// also used by the IR and decode stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_LOAD = 3'd2,
        ST_READ = 3'd3,
        ST_HOLD = 3'd4
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int unsigned FETCH_PC_INC   = 4;
    localparam int unsigned FETCH_INST_W   = 32;

endpackage

// File: rtl/fetch_pc.sv
// Program counter, request address and squash flag for the fetch sequencer,
// including the sequential-advance / branch-redirect mux.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter int              PC_INC   = FETCH_PC_INC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  fetch_state_t      state,
    input  logic              ack,
    input  logic              stall,
    input  logic              branch,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] req_addr,
    output logic              squash
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_seq;
    logic              advance;

    assign pc_seq  = pc + ADDR_W'(PC_INC);
    assign advance = (state == ST_HOLD) && !stall && !branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            squash   <= 1'b0;
        end else begin
            if (branch)
                pc <= target;
            else if (advance)
                pc <= pc_seq;

            if (state == ST_REQ) begin
                // The address must stay stable until ack, so a redirect during
                // an outstanding request only marks it for discard.
                if (ack) begin
                    squash <= 1'b0;
                    if (branch)
                        req_addr <= target;
                    else if (squash)
                        req_addr <= pc;
                end else if (branch) begin
                    squash <= 1'b1;
                end
            end else begin
                squash <= 1'b0;
                if (branch)
                    req_addr <= target;
                else if (advance)
                    req_addr <= pc_seq;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: requests instruction words, writes them into the IR,
// reads them back out and holds them for decode with a valid/stall handshake.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter int                PC_INC   = FETCH_PC_INC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              IR_wr,
    output logic              IR_rd,
    output logic [31:0]       inst,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target
);

    fetch_state_t      state, state_nx;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [ADDR_W-1:0] req_addr;
    logic              squash;
    logic              accept;

    fetch_pc #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC),
        .PC_INC  (PC_INC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state),
        .ack     (imem_ack),
        .stall   (stall),
        .branch  (branch_taken),
        .target  (branch_target),
        .req_addr(req_addr),
        .squash  (squash)
    );

    // Returned word is kept only when no redirect is pending or arriving.
    assign accept = (state == ST_REQ) && imem_ack && !squash && !branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            inst_q   <= '0;
            pc_out_q <= RESET_PC;
        end else begin
            state <= state_nx;
            if (accept) begin
                inst_q   <= imem_rdata;
                pc_out_q <= req_addr;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = ST_REQ;
            ST_REQ:  if (accept) state_nx = ST_LOAD;
            ST_LOAD: state_nx = branch_taken ? ST_REQ : ST_READ;
            ST_READ: state_nx = branch_taken ? ST_REQ : ST_HOLD;
            ST_HOLD: if (branch_taken || !stall) state_nx = ST_REQ;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = req_addr;
        IR_wr     = 1'b0;
        IR_rd     = 1'b0;
        inst      = inst_q;
        ir_valid  = 1'b0;
        pc_out    = pc_out_q;
        case (state)
            ST_REQ:  imem_req = 1'b1;
            ST_LOAD: IR_wr    = 1'b1;
            ST_READ: IR_rd    = 1'b1;
            ST_HOLD: begin
                IR_rd    = 1'b1;
                ir_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small behavioural IR on the strobes.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        IR_wr, IR_rd;
    logic [31:0] inst;
    logic        ir_valid;
    logic [31:0] pc_out;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] ir_store = '0;
    logic [31:0] fetchout = '0;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .IR_wr(IR_wr), .IR_rd(IR_rd), .inst(inst),
        .ir_valid(ir_valid), .pc_out(pc_out), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    // IR model: latch on write, present on fetchout after read.
    always_ff @(posedge clk) begin
        if (IR_wr) ir_store <= inst;
        if (IR_rd) fetchout <= ir_store;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ack_with(input logic [31:0] d);
        imem_ack   = 1'b1;
        imem_rdata = d;
        step();
        imem_ack   = 1'b0;
    endtask

    initial begin
        // reset state
        @(posedge clk); @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wr", IR_wr, 0);
        chk("rst_rd", IR_rd, 0);
        chk("rst_inst", inst, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_pcout", pc_out, 0);

        // zero-wait fetch
        rst_n = 1'b1;
        step();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        chk("t1_req_wr", IR_wr, 0);
        ack_with(32'h00A00093);
        chk("t1_load_wr", IR_wr, 1);
        chk("t1_load_rd", IR_rd, 0);
        chk("t1_load_inst", inst, 32'h00A00093);
        step();
        chk("t1_read_rd", IR_rd, 1);
        chk("t1_read_wr", IR_wr, 0);
        chk("t1_read_valid", ir_valid, 0);
        step();
        chk("t1_hold_valid", ir_valid, 1);
        chk("t1_hold_pc", pc_out, 0);
        chk("t1_fetchout", fetchout, 32'h00A00093);
        step();
        chk("t1_next_req", imem_req, 1);
        chk("t1_next_addr", imem_addr, 4);
        chk("t1_next_valid", ir_valid, 0);

        // ack delayed three cycles
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_held", imem_req, 1);
            chk("t2_addr_held", imem_addr, 4);
            if (i < 3) step();
        end
        ack_with(32'h12345678);
        chk("t2_c1_valid", ir_valid, 0);
        step();
        chk("t2_c2_valid", ir_valid, 0);
        stall = 1'b1;
        step();
        chk("t2_c3_valid", ir_valid, 1);
        chk("t2_pcout", pc_out, 4);

        // stall for five cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", ir_valid, 1);
            chk("t3_rd", IR_rd, 1);
            chk("t3_pcout", pc_out, 4);
            chk("t3_noreq", imem_req, 0);
            if (i < 4) step();
        end
        stall = 1'b0;
        step();
        chk("t3_next_addr", imem_addr, 8);
        chk("t3_next_req", imem_req, 1);

        // branch while request to 8 is outstanding
        branch_taken = 1'b1; branch_target = 32'h200;
        step();
        branch_taken = 1'b0;
        chk("t5_addr_stable1", imem_addr, 8);
        chk("t5_req1", imem_req, 1);
        step();
        chk("t5_addr_stable2", imem_addr, 8);
        ack_with(32'hDEADBEEF);
        chk("t5_no_wr", IR_wr, 0);
        chk("t5_req2", imem_req, 1);
        chk("t5_new_addr", imem_addr, 32'h200);
        ack_with(32'hAAAA5555);
        chk("t5_load_wr", IR_wr, 1);
        chk("t5_load_inst", inst, 32'hAAAA5555);
        step();
        step();
        chk("t5_valid", ir_valid, 1);
        chk("t5_pcout", pc_out, 32'h200);
        chk("t5_fetchout", fetchout, 32'hAAAA5555);

        // branch in HOLD with stall low
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("t4_valid_drop", ir_valid, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h100);
        ack_with(32'h11111111);
        step();
        step();
        chk("t4_valid", ir_valid, 1);
        chk("t4_pcout", pc_out, 32'h100);
        step();
        chk("t4_seq_addr", imem_addr, 32'h104);

        // branch coinciding with ack
        branch_taken = 1'b1; branch_target = 32'h300;
        ack_with(32'h0BADF00D);
        branch_taken = 1'b0;
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 32'h300);
        chk("t6_no_wr", IR_wr, 0);

        // asynchronous reset during READ
        ack_with(32'h00000055);
        step();
        chk("t7_in_read", IR_rd, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_req", imem_req, 0);
        chk("t7_addr", imem_addr, 0);
        chk("t7_wr", IR_wr, 0);
        chk("t7_rd", IR_rd, 0);
        chk("t7_inst", inst, 0);
        chk("t7_valid", ir_valid, 0);
        chk("t7_pcout", pc_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t7_restart_req", imem_req, 1);
        chk("t7_restart_addr", imem_addr, 0);

        // squash then re-request, then PC wrap-around
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("t8_addr_stable", imem_addr, 0);
        ack_with(32'h00000013);
        chk("t8_no_wr", IR_wr, 0);
        chk("t8_addr", imem_addr, 32'hFFFF_FFFC);
        ack_with(32'h00000093);
        step();
        step();
        chk("t8_pcout", pc_out, 32'hFFFF_FFFC);
        step();
        chk("t8_wrap_addr", imem_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
